// File: rtl/vector_driver_pkg.sv
// Shared types and constants for the vector_driver sweep engine.
// Optional response signature is enabled by defining VECTOR_DRIVER_MISR_EN.
package vector_driver_pkg;

  localparam int VEC_W  = 4;
  localparam int RESP_W = 2;
  localparam int SIG_W  = 8;
  localparam logic [SIG_W-1:0] SIG_POLY = 8'h1D;

  // Sweep sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FIN     = 3'd4
  } state_e;

  // One MISR step: shift left, fold feedback polynomial, inject the response bits
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [RESP_W-1:0] d);
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? SIG_POLY : {SIG_W{1'b0}};
    return {s[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-RESP_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/vector_driver_misr.sv
// 8-bit response signature register; cleared by clr, advanced once per en.
// Only instantiated when VECTOR_DRIVER_MISR_EN is defined.
module vector_driver_misr
  import vector_driver_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Next signature: clear wins over advance, otherwise hold
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = {SIG_W{1'b0}};
    end else if (en) begin
      sig_d = misr_step(sig_q, din);
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= {SIG_W{1'b0}};
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/vector_driver.sv
// Exhaustive 4-bit stimulus sweep: drives each vector, waits SETTLE_CYCLES,
// samples the 2-bit response and presents it as a valid/ready beat.
// Define VECTOR_DRIVER_MISR_EN to add the sig port and response MISR.
module vector_driver
  import vector_driver_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [VEC_W-1:0]  drv_vec,
  input  logic [RESP_W-1:0] resp,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [VEC_W-1:0]  res_vec,
  output logic [RESP_W-1:0] res_resp
`ifdef VECTOR_DRIVER_MISR_EN
  ,
  output logic [SIG_W-1:0]  sig
`endif
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [VEC_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        settle_q, settle_d;
  logic [VEC_W-1:0]  drv_vec_q, drv_vec_d;
  logic              res_valid_q, res_valid_d;
  logic [VEC_W-1:0]  res_vec_q, res_vec_d;
  logic [RESP_W-1:0] res_resp_q, res_resp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Sequencer next-state and output-register next values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    drv_vec_d   = drv_vec_q;
    res_valid_d = res_valid_q;
    res_vec_d   = res_vec_q;
    res_resp_d  = res_resp_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          cnt_d   = {VEC_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        drv_vec_d = cnt_q;
        settle_d  = 4'd0;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        // drv_vec has been stable since DRIVE, so resp reflects it on the last cycle
        if (settle_q == SETTLE_LAST) begin
          res_resp_d  = resp;
          res_vec_d   = cnt_q;
          res_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_PRESENT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (cnt_q == 4'hF) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = ST_DRIVE;
          end
        end else begin
          state_d = ST_PRESENT;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {VEC_W{1'b0}};
      settle_q    <= 4'd0;
      drv_vec_q   <= {VEC_W{1'b0}};
      res_valid_q <= 1'b0;
      res_vec_q   <= {VEC_W{1'b0}};
      res_resp_q  <= {RESP_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      drv_vec_q   <= drv_vec_d;
      res_valid_q <= res_valid_d;
      res_vec_q   <= res_vec_d;
      res_resp_q  <= res_resp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign drv_vec   = drv_vec_q;
  assign res_valid = res_valid_q;
  assign res_vec   = res_vec_q;
  assign res_resp  = res_resp_q;

`ifdef VECTOR_DRIVER_MISR_EN
  logic misr_clr;
  logic misr_en;

  assign misr_clr = (state_q == ST_IDLE) && start;
  assign misr_en  = res_valid_q && res_ready;

  vector_driver_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (misr_en),
    .din   (res_resp_q),
    .sig   (sig)
  );
`endif

endmodule
